// File: rtl/reflet_uart_tx_periph.sv
// reflet_uart_tx_periph
// Memory-mapped 8N1 serial transmitter for the reflet_cpu system bus.
// The CPU queues bytes through TXDATA into a small FIFO; a shifter drains
// them onto tx at divisor+1 clocks per bit. STATUS reports FIFO fill,
// sticky overflow and busy; DIVISOR sets the bit period for later frames.
// irq pulses for one cycle when the line goes idle after the last byte.
// Read data is zero whenever this block is not addressed so it can be
// OR-ed onto a shared read bus.

module reflet_uart_tx_periph #(
  parameter int                  wordsize        = 16,
  parameter logic [wordsize-1:0] base_addr       = 16'hFF00,
  parameter int                  fifo_depth      = 8,
  parameter logic [wordsize-1:0] default_divisor = 16'd0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                tx,
  output logic                irq
);

  // Register map: four consecutive bus words starting at base_addr.
  localparam int                  word_bytes   = wordsize / 8;
  localparam logic [wordsize-1:0] addr_txdata  = base_addr;
  localparam logic [wordsize-1:0] addr_status  = base_addr + wordsize'(word_bytes);
  localparam logic [wordsize-1:0] addr_divisor = base_addr + wordsize'(2 * word_bytes);
  localparam logic [wordsize-1:0] addr_rsvd    = base_addr + wordsize'(3 * word_bytes);

  // FIFO geometry: pointers wrap naturally because the depth is a power of 2,
  // and the count needs one extra bit to represent "completely full".
  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // ---------------------------------------------------------------------
  // Address decode and register strobes
  // ---------------------------------------------------------------------
  logic sel_txdata;
  logic sel_status;
  logic sel_divisor;
  logic sel_rsvd;

  assign sel_txdata  = (addr == addr_txdata);
  assign sel_status  = (addr == addr_status);
  assign sel_divisor = (addr == addr_divisor);
  assign sel_rsvd    = (addr == addr_rsvd);

  logic push_req;
  logic status_wr;
  logic divisor_wr;

  assign push_req   = write_en & sel_txdata;
  assign status_wr  = write_en & sel_status;
  assign divisor_wr = write_en & sel_divisor;

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  logic [wordsize-1:0] divisor;
  logic                overflow;

  // Divisor register and sticky overflow flag.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values, regardless of the order of statements or blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      divisor  <= default_divisor;
      overflow <= 1'b0;
    end else begin
      if (divisor_wr) begin
        divisor <= data_in;
      end
      if (status_wr) begin
        overflow <= 1'b0;
      end else if (push_req && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       fifo_mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Full is judged on the pre-edge count, so a push in the same cycle as a
  // pop from a full FIFO is still dropped.
  assign full  = (count == cnt_w'(fifo_depth));
  assign empty = (count == '0);
  assign push  = push_req & ~full;

  // FIFO storage write.
  // NOTE: the data array has no reset; only the pointers and count decide
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data_in[7:0];
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM and bit-timing datapath
  // ---------------------------------------------------------------------
  tx_state_t           state;
  tx_state_t           next_state;
  logic [7:0]          shifter;
  logic [wordsize-1:0] div_lat;
  logic [wordsize-1:0] baud_cnt;
  logic [2:0]          bit_cnt;
  logic                bit_done;
  logic                busy;

  // A bit ends when the per-frame counter reaches the divisor latched at
  // frame start, so a DIVISOR write mid-frame only affects the next frame.
  assign bit_done = (baud_cnt == div_lat);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: START -> 8 DATA bits -> STOP, chaining frames while
  // the FIFO has data.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          next_state = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done && (bit_cnt == 3'd7)) begin
          next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          next_state = empty ? ST_IDLE : ST_START;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: line level, busy flag and FIFO pop (which also loads the
  // shifter for a new frame).
  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        pop  = ~empty;
      end
      ST_START: begin
        tx = 1'b0;
      end
      ST_DATA: begin
        tx = shifter[0];
      end
      ST_STOP: begin
        pop = bit_done & ~empty;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Bit timing, LSB-first shifter, per-frame divisor latch and idle irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      shifter  <= '0;
      div_lat  <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      irq      <= 1'b0;
    end else begin
      irq <= (state == ST_STOP) && bit_done && empty;
      if (pop) begin
        shifter  <= fifo_mem[rd_ptr];
        div_lat  <= divisor;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state != ST_IDLE) begin
        if (bit_done) begin
          baud_cnt <= '0;
          if (state == ST_DATA) begin
            shifter <= shifter >> 1;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + wordsize'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [7:0]          count8;
  logic [wordsize-1:0] rd_value;

  assign count8 = 8'(count);

  // Read mux: TXDATA, the reserved word and unselected addresses read as 0.
  always_comb begin
    rd_value = '0;
    if (sel_status) begin
      rd_value[15:8] = count8;
      rd_value[4]    = overflow;
      rd_value[3]    = busy;
      rd_value[1]    = empty;
      rd_value[0]    = full;
    end else if (sel_divisor) begin
      rd_value = divisor;
    end else if (sel_rsvd || sel_txdata) begin
      rd_value = '0;
    end
  end

  // Registered read data: value for the address sampled at an edge is held
  // until the following edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else begin
      data_out <= rd_value;
    end
  end

endmodule

// File: tb/tb_reflet_uart_tx_periph.sv
// Self-checking bench for reflet_uart_tx_periph.
// Bytes written to TXDATA are pushed onto a scoreboard queue; a line
// monitor decodes every frame on tx using the bench's own divisor value,
// checks bit widths and stop bit, and compares the byte with the queue.

module tb_reflet_uart_tx_periph;

  localparam int          WS      = 16;
  localparam logic [15:0] BASE    = 16'hFF00;
  localparam int          DEPTH   = 8;
  localparam logic [15:0] DEF_DIV = 16'd0;

  localparam logic [15:0] A_TX  = BASE;
  localparam logic [15:0] A_ST  = BASE + 16'd2;
  localparam logic [15:0] A_DIV = BASE + 16'd4;
  localparam logic [15:0] A_RSV = BASE + 16'd6;
  localparam logic [15:0] A_LOW = BASE - 16'd2;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          write_en = 1'b0;
  logic [15:0]   addr     = 16'h0000;
  logic [15:0]   data_in  = 16'h0000;
  logic [15:0]   data_out;
  logic          tx;
  logic          irq;

  always #5 clk = ~clk;

  reflet_uart_tx_periph #(
    .wordsize       (WS),
    .base_addr      (BASE),
    .fifo_depth     (DEPTH),
    .default_divisor(DEF_DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .data_in (data_in),
    .write_en(write_en),
    .data_out(data_out),
    .tx      (tx),
    .irq     (irq)
  );

  int         n_cmp     = 0;
  int         n_bad     = 0;
  logic [7:0] exp_q[$];
  int         mdl_div   = 0;
  int         frame_cnt = 0;
  int         irq_cnt   = 0;
  bit         in_frame  = 1'b0;
  logic       irq_prev  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr     = a;
    data_in  = d;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    bus_write(A_TX, {8'h00, b});
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    addr     = a;
    write_en = 1'b0;
    @(negedge clk);
    d = data_out;
  endtask

  task automatic wait_tx_low(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1);
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_frame) begin
        done = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    check(tag, done, 1);
  endtask

  // irq pulse counter and width check
  always @(negedge clk) begin
    if (irq === 1'b1) begin
      irq_cnt++;
      check("irq_width", irq_prev, 0);
    end
    irq_prev = irq;
  end

  // line monitor: decode frames, compare with scoreboard
  initial begin : line_mon
    bit         gap_pending;
    bit         want_b2b;
    logic [9:0] bits;
    bit         glitch;
    bit         aborted;
    int         d;
    logic [7:0] exp_b;
    gap_pending = 1'b0;
    want_b2b    = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame    = 1'b0;
        gap_pending = 1'b0;
        continue;
      end
      if (gap_pending) begin
        gap_pending = 1'b0;
        check("frame_gap_tx", tx, want_b2b ? 1'b0 : 1'b1);
        check("irq_at_idle", irq, want_b2b ? 1'b0 : 1'b1);
      end
      if (tx === 1'b0) begin
        in_frame = 1'b1;
        d        = mdl_div;
        glitch   = 1'b0;
        aborted  = 1'b0;
        bits     = '0;
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) exp_b = exp_q.pop_front();
        else                  exp_b = 8'h00;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c <= d && !aborted; c++) begin
            if (b != 0 || c != 0) begin
              @(negedge clk);
              if (reset) aborted = 1'b1;
            end
            if (!aborted) begin
              if (c == 0)                bits[b] = tx;
              else if (tx !== bits[b])   glitch  = 1'b1;
            end
          end
        end
        in_frame = 1'b0;
        if (!aborted) begin
          check("frame_data", bits[8:1], exp_b);
          check("stop_bit", bits[9], 1);
          check("bit_width", glitch, 0);
          frame_cnt++;
          gap_pending = 1'b1;
          want_b2b    = (exp_q.size() > 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] rd;
    int          f0;
    int          i0;
    int          busy_n;

    // reset state
    mdl_div = int'(DEF_DIV);
    addr    = A_DIV;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", data_out, 0);
    check("rst_tx", tx, 1);
    check("rst_irq", irq, 0);
    reset = 1'b0;
    bus_read(A_ST, rd);
    check("rst_status", rd, 16'h0002);
    bus_read(A_DIV, rd);
    check("rst_divisor", rd, DEF_DIV);

    // single frame, divisor 3, busy throughout
    bus_write(A_DIV, 16'd3);
    mdl_div = 3;
    bus_read(A_DIV, rd);
    check("div_readback", rd, 16'd3);
    f0 = frame_cnt;
    i0 = irq_cnt;
    push_byte(8'h55);
    addr = A_ST;
    wait_tx_low("t1_start");
    busy_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (data_out[3]) busy_n++;
    end
    check("t1_busy_cycles", busy_n, 40);
    @(negedge clk);
    check("t1_busy_after", data_out[3], 0);
    wait_drain("t1_drain");
    check("t1_frames", frame_cnt - f0, 1);
    check("t1_irqs", irq_cnt - i0, 1);

    // overflow with divisor 0
    bus_write(A_DIV, 16'd0);
    mdl_div = 0;
    f0 = frame_cnt;
    i0 = irq_cnt;
    push_byte(8'h11);
    wait_tx_low("t2_start");
    for (int i = 0; i < 9; i++) begin
      addr     = A_TX;
      data_in  = 16'h0080 + 16'(i);
      write_en = 1'b1;
      if (i < DEPTH) exp_q.push_back(8'h80 + 8'(i));
      @(negedge clk);
    end
    write_en = 1'b0;
    addr     = A_ST;
    @(negedge clk);
    check("t2_status_full_ovf", data_out, 16'h0819);
    bus_write(A_ST, 16'hFFFF);
    bus_read(A_ST, rd);
    check("t2_ovf_cleared", rd[4], 0);
    wait_drain("t2_drain");
    check("t2_frames", frame_cnt - f0, 9);
    check("t2_irqs", irq_cnt - i0, 1);

    // two queued bytes go out back to back, one irq
    bus_write(A_DIV, 16'd2);
    mdl_div = 2;
    f0 = frame_cnt;
    i0 = irq_cnt;
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_drain("t3_drain");
    check("t3_frames", frame_cnt - f0, 2);
    check("t3_irqs", irq_cnt - i0, 1);

    // divisor change mid-frame applies to next frame only
    bus_write(A_DIV, 16'd3);
    mdl_div = 3;
    f0 = frame_cnt;
    i0 = irq_cnt;
    push_byte(8'hC3);
    push_byte(8'h0F);
    wait_tx_low("t4_start");
    repeat (10) @(negedge clk);
    bus_write(A_DIV, 16'd1);
    mdl_div = 1;
    wait_drain("t4_drain");
    check("t4_frames", frame_cnt - f0, 2);
    check("t4_irqs", irq_cnt - i0, 1);
    bus_read(A_DIV, rd);
    check("t4_div_readback", rd, 16'd1);

    // reset during DATA abandons the frame
    bus_write(A_DIV, 16'd3);
    mdl_div = 3;
    push_byte(8'h00);
    wait_tx_low("t5_start");
    repeat (6) @(negedge clk);
    f0    = frame_cnt;
    i0    = irq_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("t5_tx_reset", tx, 1);
    check("t5_irq_reset", irq, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    mdl_div = int'(DEF_DIV);
    bus_read(A_ST, rd);
    check("t5_status", rd, 16'h0002);
    bus_read(A_DIV, rd);
    check("t5_divisor", rd, DEF_DIV);
    bus_write(A_RSV, 16'h1234);
    bus_read(A_RSV, rd);
    check("t5_rsvd_read", rd, 0);
    bus_read(A_LOW, rd);
    check("t5_below_base", rd, 0);
    bus_read(A_DIV, rd);
    check("t5_rsvd_write_ignored", rd, DEF_DIV);
    repeat (50) @(negedge clk);
    check("t5_no_frame", frame_cnt - f0, 0);
    check("t5_no_irq", irq_cnt - i0, 0);
    check("t5_tx_idle", tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
